// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide (HI/LO) unit.
package mips_muldiv_pkg;

  localparam int DATA_W       = 32;
  localparam int MULDIV_ITERS = 32;
  localparam int CNT_W        = $clog2(MULDIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITERS - 1);

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // Everything the FIX step needs to know about the operation in flight.
  typedef struct packed {
    logic is_div;    // divide (HI=remainder, LO=quotient) vs multiply
    logic neg_res;   // product / quotient must be negated
    logic neg_rem;   // remainder takes the (negative) sign of the dividend
    logic div_zero;  // divisor was zero: quotient forced to all ones
  } muldiv_ctl_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  // Two's-complement negate when neg is set; magnitude of a negative signed value.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned iterative multiply/divide datapath: one shift-add (multiply) or
// restoring shift-subtract (divide) step per enabled cycle on a 64-bit
// accumulator. After 32 steps acc_o holds {product} or {remainder, quotient}.
module mips_muldiv_core
  import mips_muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                load_i,
  input  logic                step_i,
  input  logic                is_div_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] acc_o
);

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_d;
  logic [DATA_W-1:0]   b_q;
  logic                div_q;

  logic [DATA_W:0]     mul_sum;
  logic                div_fits;
  logic [DATA_W-1:0]   div_rem;

  // Compute the accumulator value after one iteration of the latched mode.
  always_comb begin
    // Multiply: conditionally add multiplicand to the upper half, then shift
    // right keeping the carry; the multiplier drains out of the lower half.
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q};
    // Divide: the partial remainder after the left shift is 33 bits wide
    // (acc_q[63:31]); subtract only when the divisor fits.
    div_fits = (acc_q[2*DATA_W-1:DATA_W-1] >= {1'b0, b_q});
    // The true difference is below the divisor, so its low 32 bits are exact.
    div_rem  = acc_q[2*DATA_W-2:DATA_W-1] - b_q;

    // NOTE: a default assignment ahead of the branches keeps every path
    // assigned, so no latch can be inferred from this combinational block.
    acc_d = acc_q;
    if (div_q) begin
      if (div_fits) begin
        acc_d = {div_rem, acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
      end
    end
  end

  // Load fresh operands on start; otherwise advance one step when enabled.
  // NOTE: these datapath registers carry no reset: they are always loaded
  // before they are used, and the controlling FSM's reset is what aborts an
  // operation safely.
  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q <= {{DATA_W{1'b0}}, a_i};
      b_q   <= b_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mips_hilo_unit.sv
// MIPS multiply/divide unit owning the architectural HI/LO registers.
// Signed operations are reduced to magnitudes for the unsigned core and the
// sign is restored in FIX. busy stalls decode for 33 cycles per operation;
// MTHI/MTLO write directly while idle.
module mips_hilo_unit
  import mips_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] move_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t    state_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  muldiv_ctl_t      ctl_q;
  muldiv_ctl_t      ctl_d;

  muldiv_op_t       op_in;
  logic             neg_a;
  logic             neg_b;
  logic [31:0]      core_a;
  logic [31:0]      core_b;
  logic             core_load;
  logic             core_step;
  logic [63:0]      core_acc;

  logic [63:0]      prod_fix;
  logic [31:0]      quot_fix;
  logic [31:0]      rem_fix;
  logic [31:0]      hi_d;
  logic [31:0]      lo_d;

  // Decode the incoming request into sign flags and unsigned core operands.
  always_comb begin
    op_in          = muldiv_op_t'(op);
    neg_a          = op_is_signed(op_in) & operand_a[31];
    neg_b          = op_is_signed(op_in) & operand_b[31];
    core_a         = neg_if(operand_a, neg_a);
    core_b         = neg_if(operand_b, neg_b);
    ctl_d.is_div   = op_is_div(op_in);
    ctl_d.neg_res  = neg_a ^ neg_b;
    ctl_d.neg_rem  = neg_a;
    ctl_d.div_zero = (operand_b == 32'd0);
  end

  // The core loads only on an accepted start and iterates only in CALC.
  assign core_load = (state_q == IDLE) && start;
  assign core_step = (state_q == CALC);

  mips_muldiv_core u_core (
    .clk      (clk),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (ctl_d.is_div),
    .a_i      (core_a),
    .b_i      (core_b),
    .acc_o    (core_acc)
  );

  // Restore signs on the finished core result and select the HI/LO pair.
  always_comb begin
    prod_fix = ctl_q.neg_res ? (~core_acc + 64'd1) : core_acc;
    quot_fix = neg_if(core_acc[31:0], ctl_q.neg_res);
    // Divide by zero leaves |dividend| as the remainder, so the dividend's
    // sign turns HI back into operand_a for signed DIV too.
    rem_fix  = neg_if(core_acc[63:32], ctl_q.neg_rem);

    hi_d = prod_fix[63:32];
    lo_d = prod_fix[31:0];
    if (ctl_q.is_div) begin
      hi_d = rem_fix;
      lo_d = ctl_q.div_zero ? 32'hFFFF_FFFF : quot_fix;
    end
  end

  // Sequence IDLE -> CALC -> FIX, handle MTHI/MTLO, and own HI/LO and busy.
  // NOTE: all state here uses non-blocking assignments so every register
  // updates from values sampled before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ctl_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Start wins over a same-cycle MTHI/MTLO.
            ctl_q   <= ctl_d;
            cnt_q   <= '0;
            state_q <= CALC;
            busy_q  <= 1'b1;
          end else begin
            if (mthi) hi_q <= move_data;
            if (mtlo) lo_q <= move_data;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_hilo_unit.sv
// Self-checking bench for mips_hilo_unit: a cycle-level behavioural model
// (plain 64-bit arithmetic plus a remaining-latency count) is compared
// against the DUT every cycle, with directed literal checks for the corner
// cases and a long randomized phase.
module tb_mips_hilo_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] move_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_pend_hi = '0;
  logic [31:0] m_pend_lo = '0;
  int          m_rem = 0;

  mips_hilo_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .move_data (move_data),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic. 0=MULT 1=MULTU 2=DIV 3=DIVU.
  function automatic logic [63:0] model_calc(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Cycle-level model: a start makes the unit busy for 33 edges, then the
  // result lands; MTHI/MTLO land on the next edge when idle and not starting.
  always @(posedge clk) begin
    if (reset) begin
      m_hi  = '0;
      m_lo  = '0;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (start) begin
      {m_pend_hi, m_pend_lo} = model_calc(op, operand_a, operand_b);
      m_rem = 33;
    end else begin
      if (mthi) m_hi = move_data;
      if (mtlo) m_lo = move_data;
    end
  end

  // Compare DUT outputs to the model mid-cycle, every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("cyc hi", hi, m_hi);
      check("cyc lo", lo, m_lo);
    end
  end

  // Issue one operation from a negedge; return at the negedge where busy
  // drops so another start can follow back-to-back.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic [31:0] hold_hi,
                        input logic [31:0] hold_lo, input bit mt_at_start, input bit poke);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    mthi = mt_at_start;
    mtlo = mt_at_start;
    move_data = 32'hFFFF_0000;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
      end
      if (busy) begin
        n++;
        check({name, " hold hi"}, hi, hold_hi);
        check({name, " hold lo"}, lo, hold_lo);
        if (poke && k == 5) begin
          start = 1'b1;
          mthi = 1'b1;
          mtlo = 1'b1;
          move_data = 32'hAAAA_AAAA;
        end
        if (k == 6) begin
          start = 1'b0;
          mthi = 1'b0;
          mtlo = 1'b0;
        end
      end else begin
        done = 1'b1;
      end
    end
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    check({name, " busy cycles"}, 32'(n), 32'd33);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'($urandom_range(0, 20));
      5: begin
        v = 32'($urandom_range(1, 20));
        v = ~v + 32'd1;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] mr;

    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    operand_a = '0;
    operand_b = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    move_data = '0;

    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    cmp_en = 1'b1;
    reset = 1'b0;

    // Model pins against hand-computed results.
    mr = model_calc(2'd0, 32'hFFFF_FFFE, 32'd3);
    check("model MULT hi", mr[63:32], 32'hFFFF_FFFF);
    check("model MULT lo", mr[31:0], 32'hFFFF_FFFA);
    mr = model_calc(2'd2, 32'hFFFF_FFF9, 32'd2);
    check("model DIV hi", mr[63:32], 32'hFFFF_FFFF);
    check("model DIV lo", mr[31:0], 32'hFFFF_FFFD);
    mr = model_calc(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("model DIV ovf lo", mr[31:0], 32'h8000_0000);

    // MTHI + MTLO together, then each alone.
    @(negedge clk);
    mthi = 1'b1;
    mtlo = 1'b1;
    move_data = 32'h0F0F_0F0F;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt both hi", hi, 32'h0F0F_0F0F);
    check("mt both lo", lo, 32'h0F0F_0F0F);
    mthi = 1'b1;
    move_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi hi", hi, 32'hDEAD_BEEF);
    check("mthi lo", lo, 32'h0F0F_0F0F);
    mtlo = 1'b1;
    move_data = 32'h1234_5678;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo hi", hi, 32'hDEAD_BEEF);
    check("mtlo lo", lo, 32'h1234_5678);

    // Directed operations, chained back-to-back.
    run_op("MULT -2*3", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
           32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
    run_op("MULTU max*max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("DIV -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("DIVU 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("DIVU 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF,
           32'd2, 32'd14, 1'b0, 1'b0);
    run_op("DIV min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
           32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("DIV -7/0", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("MULT max*min", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset in cycle 10 of a MULT aborts it.
    start = 1'b1;
    op = 2'd0;
    operand_a = 32'd3;
    operand_b = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    reset = 1'b0;
    run_op("MULT after abort", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15,
           32'd0, 32'd0, 1'b0, 1'b0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 3) == 0);
      op        = 2'($urandom_range(0, 3));
      operand_a = rand_operand();
      operand_b = rand_operand();
      mthi      = ($urandom_range(0, 4) == 0);
      mtlo      = ($urandom_range(0, 4) == 0);
      move_data = $urandom;
      reset     = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("final idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
